// File: rtl/shifter_pkg.sv
// shifter_pkg: shift encodings, FSM states and the effective-amount / initial-carry rule
package shifter_pkg;

    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} sh_e;
    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;
    typedef enum logic [1:0] {C_KEEP = 2'b00, C_LSB = 2'b01, C_MSB = 2'b10} csrc_e;

    typedef struct packed {
        int unsigned eff;
        csrc_e       csrc;
        logic        rrx;
    } init_t;

    // RRX is resolved at acceptance, so it reports eff=0 and leaves one plain SHIFT cycle
    function automatic init_t calc_init(input logic [1:0] sh, input logic reg_shift,
                                        input int unsigned n, input int unsigned width);
        init_t r;
        r.eff  = 0;
        r.csrc = C_KEEP;
        r.rrx  = 1'b0;
        if (n == 0 && !reg_shift) begin
            if (sh == SH_LSR || sh == SH_ASR) r.eff = width;
            else if (sh == SH_ROR) begin
                r.rrx  = 1'b1;
                r.csrc = C_LSB;
            end
        end else if (n != 0) begin
            if (sh == SH_LSL || sh == SH_LSR) r.eff = (n > width + 1) ? width + 1 : n;
            else if (sh == SH_ASR) r.eff = (n > width) ? width : n;
            else begin
                r.eff  = n % width;
                r.csrc = (r.eff == 0) ? C_MSB : C_KEEP;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_iter_shift_step.sv
// shift_step: combinational shift of a word by 0..STEP bits, with the last bit shifted out
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] val,
    input  logic [KW-1:0]    k,
    input  logic [1:0]       sh,
    output logic [WIDTH-1:0] res,
    output logic             cout
);

    logic [WIDTH:0]   l, r, a;
    logic [WIDTH-1:0] o;

    // one guard bit on the outgoing side captures the last bit shifted out
    assign l = {1'b0, val} << k;
    assign r = {val, 1'b0} >> k;
    assign a = $signed({val, 1'b0}) >>> k;
    assign o = (val >> k) | (val << (WIDTH - int'(k)));

    always_comb begin
        res  = (sh == SH_LSL) ? l[WIDTH-1:0] : (sh == SH_LSR) ? r[WIDTH:1] :
               (sh == SH_ASR) ? a[WIDTH:1] : o;
        cout = (sh == SH_LSL) ? l[WIDTH] : (sh == SH_LSR) ? r[0] :
               (sh == SH_ASR) ? a[0] : o[WIDTH-1];
    end

endmodule

// File: rtl/shifter_iter.sv
// shifter_iter: multi-cycle ARM barrel shifter, up to STEP bits per cycle with start/busy/done handshake
module shifter_iter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int STEP  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       Sh,
    input  logic             RegShift,
    input  logic [AMT_W-1:0] Amt,
    input  logic [WIDTH-1:0] ShIn,
    input  logic             C_in,
    output logic [WIDTH-1:0] ShOut,
    output logic             CarryOut,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int KW = $clog2(STEP + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, step_res;
    logic [CW-1:0]    rem_q, rem_d;
    logic [1:0]       sh_q, sh_d;
    logic             carry_q, carry_d, done_q, done_d, step_c;
    logic             busy, accept, last;
    logic [KW-1:0]    k;
    int unsigned      n;
    init_t            ini;

    assign busy   = state_q == S_SHIFT;
    assign accept = Start && !busy;
    assign last   = rem_q <= CW'(STEP);
    assign k      = (rem_q >= CW'(STEP)) ? KW'(STEP) : KW'(rem_q);
    assign n      = RegShift ? 32'(Amt) : 32'(Amt[4:0]);
    assign ini    = calc_init(Sh, RegShift, n, WIDTH);

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
        .val (work_q),
        .k   (k),
        .sh  (sh_q),
        .res (step_res),
        .cout(step_c)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
            sh_q    <= SH_LSL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = accept ? S_SHIFT : (busy && last) ? S_IDLE : state_q;
    end

    always_comb begin
        work_d   = accept ? (ini.rrx ? {C_in, ShIn[WIDTH-1:1]} : ShIn) : busy ? step_res : work_q;
        carry_d  = accept ? ((ini.csrc == C_LSB) ? ShIn[0] : (ini.csrc == C_MSB) ? ShIn[WIDTH-1] : C_in) :
                   (busy && k != '0) ? step_c : carry_q;
        rem_d    = accept ? CW'(ini.eff) : busy ? rem_q - CW'(k) : rem_q;
        sh_d     = accept ? Sh : sh_q;
        done_d   = busy && last;
        ShOut    = work_q;
        CarryOut = carry_q;
        Busy     = busy;
        Done     = done_q;
    end

endmodule
